key_scan_ctrl: RTL



---
 rtl/key_scan_pkg.sv | 26 ++
 rtl/key_event_fifo.sv | 47 ++++
 rtl/key_scan_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/key_scan_pkg.sv
// Register map, bit positions and event format shared by the key scan controller files.
package key_scan_pkg;
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_DIV_LO  = 16;

    localparam int STAT_EMPTY   = 4;
    localparam int STAT_FULL    = 5;
    localparam int STAT_OVF     = 6;
    localparam int STAT_CLR_OVF = 4;
    localparam int STAT_FLUSH   = 5;

    localparam int DATA_VALID   = 31;
    localparam int EVT_W        = 3;

    localparam logic [15:0] DIV_RST_DFLT = 16'd999;

    typedef struct packed {
        logic       press;
        logic [1:0] idx;
    } key_evt_t;
endpackage

// File: rtl/key_event_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted only when a pop frees a slot.
module key_event_fifo
    import key_scan_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [EVT_W-1:0]         din,
    output logic [EVT_W-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [EVT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge HCLK) begin
        if (HRESET || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge HCLK) begin
        if (do_push && !flush) mem[wptr] <= din;
    end
endmodule

// File: rtl/key_scan_ctrl.sv
// AHB-Lite key scanner: two-flop sync, prescaled round-robin debounce of four keys,
// and an event FIFO drained through the DATA register.
module key_scan_ctrl
    import key_scan_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter int          DB_SAMPLES = 4,
    parameter logic [15:0] DIV_RST    = DIV_RST_DFLT
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        KEY_IRQ,
    input  logic [3:0]  KEY
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            dp_vld, dp_wr;
    logic [1:0]      dp_addr;
    logic            rd_acc, wr_acc, pop, flush, ovf_clr;
    logic [3:0]      key_s1, key_s2;
    logic [15:0]     pcnt, div;
    logic            en, irq_en, ovf, tick;
    logic [1:0]      scan_idx;
    logic [3:0]      stable, flip;
    logic [3:0][2:0] dbc;
    logic            push, full, empty;
    key_evt_t        push_evt, head_evt;
    logic [CW-1:0]   count;
    logic [3:0]      count4;
    logic            unused_bus;

    assign unused_bus = ^{HTRANS[0], HADDR[31:4], HADDR[1:0], HWDATA[15:6], HWDATA[3:2]};
    assign HREADYOUT  = 1'b1;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_vld  <= 1'b0;
            dp_wr   <= 1'b0;
            dp_addr <= '0;
        end else begin
            dp_vld  <= HSEL && HREADY && HTRANS[1];
            dp_wr   <= HWRITE;
            dp_addr <= HADDR[3:2];
        end
    end

    assign rd_acc  = dp_vld && !dp_wr;
    assign wr_acc  = dp_vld && dp_wr;
    assign pop     = rd_acc && dp_addr == REG_DATA;
    assign flush   = wr_acc && dp_addr == REG_STATUS && HWDATA[STAT_FLUSH];
    assign ovf_clr = wr_acc && dp_addr == REG_STATUS && HWDATA[STAT_CLR_OVF];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            en     <= 1'b1;
            irq_en <= 1'b0;
            div    <= DIV_RST;
        end else if (wr_acc && dp_addr == REG_CTRL) begin
            en     <= HWDATA[CTRL_EN];
            irq_en <= HWDATA[CTRL_IRQ_EN];
            div    <= HWDATA[31:CTRL_DIV_LO];
        end
    end

    // >= rather than == so lowering DIV below the running count ticks at once
    // instead of wrapping through 65535.
    assign tick = en && (pcnt >= div);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            key_s1   <= '0;
            key_s2   <= '0;
            pcnt     <= '0;
            scan_idx <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            pcnt   <= (!en || tick) ? 16'd0 : pcnt + 16'd1;
            if (tick) scan_idx <= scan_idx + 2'd1;
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_db
        logic       hit, stb;
        logic [2:0] cnt;

        assign hit       = tick && scan_idx == 2'(k);
        assign flip[k]   = hit && key_s2[k] != stb && cnt == 3'(DB_SAMPLES - 1);
        assign stable[k] = stb;
        assign dbc[k]    = cnt;

        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                stb <= 1'b0;
                cnt <= '0;
            end else if (hit) begin
                cnt <= (key_s2[k] == stb || flip[k]) ? 3'd0 : cnt + 3'd1;
                if (flip[k]) stb <= ~stb;
            end
        end
    end

    // Only the scanned key can flip, so the event comes from scan_idx.
    assign push           = |flip;
    assign push_evt.press = key_s2[scan_idx];
    assign push_evt.idx   = scan_idx;

    key_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .din    (push_evt),
        .head   (head_evt),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) ovf <= 1'b0;
        else        ovf <= (push && !flush && full && !pop) || (ovf && !ovf_clr);
    end

    assign count4  = 4'(count);
    assign KEY_IRQ = irq_en && !empty;

    always_comb begin
        HRDATA = '0;
        if (rd_acc) begin
            case (dp_addr)
                REG_DATA: if (!empty) begin
                    HRDATA[DATA_VALID]  = 1'b1;
                    HRDATA[EVT_W-1:0]   = head_evt;
                end
                REG_STATUS: begin
                    HRDATA[3:0]        = count4;
                    HRDATA[STAT_EMPTY] = empty;
                    HRDATA[STAT_FULL]  = full;
                    HRDATA[STAT_OVF]   = ovf;
                end
                REG_CTRL: begin
                    HRDATA[CTRL_EN]       = en;
                    HRDATA[CTRL_IRQ_EN]   = irq_en;
                    HRDATA[31:CTRL_DIV_LO] = div;
                end
                default: HRDATA = '0;
            endcase
        end
    end
endmodule
